// File: rtl/pipe_pkg.sv
// Shared MEM/WB definitions: load types, link offset
// and the latched MEM/WB bundle.
package pipe_pkg;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  localparam int LINK_OFFSET_DEF = 8;

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic [4:0]  wa;
    logic        memtoreg;
    logic        link;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
  } memwb_t;

endpackage

// File: rtl/load_align.sv
// Big-endian load lane select and extension,
// plus misaligned-access detection.
module load_align
  import pipe_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // lane k sits at bits [31-8k -: 8]; 3-k == ~k
  assign w_shift = i_rdata >> {~i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr_lo[1] ? i_rdata[15:0]
                                : i_rdata[31:16];

  // extend selected lane and flag bad alignment
  always_comb begin
    o_data       = i_rdata;
    o_misaligned = 1'b0;
    unique case (i_ld_type)
      LD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU: o_data = {24'd0, w_byte};
      LD_LH: begin
        o_data       = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      LD_LHU: begin
        o_data       = {16'd0, w_half};
        o_misaligned = i_addr_lo[0];
      end
      default: o_misaligned = |i_addr_lo;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB latch and writeback datapath: drives the
// regfile write port, forwarding tap and retire count.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int LINK_OFFSET = LINK_OFFSET_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_regWr,
  input  logic [4:0]       in_writeimport,
  input  logic             in_memtoreg,
  input  logic             in_link,
  input  logic [2:0]       in_ld_type,
  input  logic [1:0]       in_addr_lo,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_rdata,
  input  logic [31:0]      in_pc,
  output logic [4:0]       writeimport,
  output logic [31:0]      Writedata,
  output logic             regWr,
  output logic             fwd_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_count
);

  memwb_t           r_q;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0] w_ld_data;
  logic        w_ld_mis;
  logic        w_mis;
  logic        w_accept;

  load_align u_align (
    .i_rdata      (r_q.rdata),
    .i_ld_type    (r_q.ld_type),
    .i_addr_lo    (r_q.addr_lo),
    .o_data       (w_ld_data),
    .o_misaligned (w_ld_mis)
  );

  assign w_mis    = r_q.valid & r_q.memtoreg & w_ld_mis;
  assign w_accept = ~flush & ~stall & in_valid;

  // pipeline latch: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (flush) begin
      r_q <= '0;
    end else if (!stall) begin
      r_q.valid    <= in_valid;
      r_q.reg_wr   <= in_regWr;
      r_q.wa       <= in_writeimport;
      r_q.memtoreg <= in_memtoreg;
      r_q.link     <= in_link;
      r_q.ld_type  <= in_ld_type;
      r_q.addr_lo  <= in_addr_lo;
      r_q.alu      <= in_alu_result;
      r_q.rdata    <= in_mem_rdata;
      r_q.pc       <= in_pc;
    end
  end

  // sticky misalign flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_mis) begin
      r_err <= 1'b1;
    end
  end

  // retire counter over accepted valid entries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // writeback value select, link over load
  always_comb begin
    if (r_q.link) begin
      Writedata = r_q.pc + 32'(LINK_OFFSET);
    end else if (r_q.memtoreg) begin
      Writedata = w_ld_data;
    end else begin
      Writedata = r_q.alu;
    end
  end

  assign writeimport  = r_q.wa;
  assign regWr        = r_q.valid & r_q.reg_wr &
                        (|r_q.wa) & ~w_mis;
  assign fwd_valid    = regWr;
  assign misalign_err = r_err;
  assign retire_count = r_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage
// against a high-level writeback model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        iv, irw, imtr, ilink;
  logic [4:0]  iwa;
  logic [2:0]  ildt;
  logic [1:0]  ialo;
  logic [31:0] ialu, ird, ipc;

  logic [4:0]  writeimport;
  logic [31:0] Writedata;
  logic        regWr, fwd_valid, misalign_err;
  logic [31:0] retire_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];

  logic        m_v, m_rw, m_mtr, m_link, m_err;
  logic [4:0]  m_wa;
  logic [2:0]  m_ldt;
  logic [1:0]  m_alo;
  logic [31:0] m_alu, m_rd, m_pc, m_cnt;

  wb_stage #(.LINK_OFFSET(8), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .in_valid       (iv),
    .in_regWr       (irw),
    .in_writeimport (iwa),
    .in_memtoreg    (imtr),
    .in_link        (ilink),
    .in_ld_type     (ildt),
    .in_addr_lo     (ialo),
    .in_alu_result  (ialu),
    .in_mem_rdata   (ird),
    .in_pc          (ipc),
    .writeimport    (writeimport),
    .Writedata      (Writedata),
    .regWr          (regWr),
    .fwd_valid      (fwd_valid),
    .misalign_err   (misalign_err),
    .retire_count   (retire_count)
  );

  always #5 clk = ~clk;

  // regfile commits the write port on the falling edge
  always @(negedge clk) begin
    if (regWr) rf[writeimport] <= Writedata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_ext(
    input logic [31:0] rd, input int t, input int k);
    logic [31:0] b, h;
    b = (rd >> (8 * (3 - k))) & 32'hFF;
    h = (k >= 2) ? (rd & 32'hFFFF) : (rd >> 16);
    case (t)
      1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      2: return b;
      3: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      4: return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit mdl_bad(input int t, input int k);
    if (t == 3 || t == 4) return (k % 2) == 1;
    if (t == 1 || t == 2) return 1'b0;
    return k != 0;
  endfunction

  function automatic bit e_mis();
    return m_v && m_mtr && mdl_bad(int'(m_ldt), int'(m_alo));
  endfunction

  function automatic logic [31:0] e_data();
    if (m_link) return m_pc + 32'd8;
    if (m_mtr) return mdl_ext(m_rd, int'(m_ldt), int'(m_alo));
    return m_alu;
  endfunction

  function automatic bit e_we();
    return m_v && m_rw && (m_wa != 0) && !e_mis();
  endfunction

  task automatic clr_fields();
    m_v = 0; m_rw = 0; m_mtr = 0; m_link = 0;
    m_wa = 0; m_ldt = 0; m_alo = 0;
    m_alu = 0; m_rd = 0; m_pc = 0;
  endtask

  // advance model with current inputs, then one edge
  task automatic tick();
    if (!rst_n) begin
      clr_fields();
      m_err = 0;
      m_cnt = 0;
    end else begin
      if (e_mis()) m_err = 1;
      if (!flush && !stall && iv) m_cnt = m_cnt + 1;
      if (flush) clr_fields();
      else if (!stall) begin
        m_v = iv; m_rw = irw; m_mtr = imtr;
        m_link = ilink; m_wa = iwa; m_ldt = ildt;
        m_alo = ialo; m_alu = ialu; m_rd = ird;
        m_pc = ipc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic full_chk(input string tag);
    chk({tag, ".wa"},  32'(writeimport), 32'(m_wa));
    chk({tag, ".wd"},  Writedata, e_data());
    chk({tag, ".we"},  32'(regWr), 32'(e_we()));
    chk({tag, ".fwd"}, 32'(fwd_valid), 32'(e_we()));
    chk({tag, ".err"}, 32'(misalign_err), 32'(m_err));
    chk({tag, ".cnt"}, retire_count, m_cnt);
  endtask

  task automatic rnd_in();
    iv    = 1'($urandom);
    irw   = 1'($urandom);
    iwa   = 5'($urandom);
    imtr  = 1'($urandom);
    ilink = ($urandom_range(0, 3) == 0);
    ildt  = 3'($urandom);
    ialo  = 2'($urandom);
    ialu  = $urandom;
    ird   = $urandom;
    ipc   = $urandom;
  endtask

  task automatic ins(input logic v, input logic rw,
                     input logic [4:0] wa,
                     input logic mtr, input logic lnk,
                     input logic [2:0] ldt,
                     input logic [1:0] alo,
                     input logic [31:0] alu,
                     input logic [31:0] rd,
                     input logic [31:0] pc);
    stall = 0; flush = 0;
    iv = v; irw = rw; iwa = wa; imtr = mtr;
    ilink = lnk; ildt = ldt; ialo = alo;
    ialu = alu; ird = rd; ipc = pc;
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  logic [31:0] c0;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    clr_fields();
    m_err = 0;
    m_cnt = 0;
    rst_n = 0; stall = 0; flush = 0;
    rnd_in();
    tick();
    rnd_in();
    tick();
    chk("rst.we",  32'(regWr), 32'd0);
    chk("rst.wd",  Writedata, 32'd0);
    chk("rst.wa",  32'(writeimport), 32'd0);
    chk("rst.fwd", 32'(fwd_valid), 32'd0);
    chk("rst.cnt", retire_count, 32'd0);
    chk("rst.err", 32'(misalign_err), 32'd0);
    rst_n = 1;

    ins(1, 1, 5, 0, 0, 0, 0, 32'h1234_5678, 0, 0);
    tick();
    chk("alu.we",  32'(regWr), 32'd1);
    chk("alu.wa",  32'(writeimport), 32'd5);
    chk("alu.wd",  Writedata, 32'h1234_5678);
    chk("alu.cnt", retire_count, 32'd1);
    @(negedge clk);
    #1;
    chk("alu.rf5", rf[5], 32'h1234_5678);

    ins(1, 1, 3, 1, 0, 3'd1, 2'd0, 0, RD, 0);
    tick();
    chk("lb0", Writedata, 32'hFFFF_FF80);
    ins(1, 1, 3, 1, 0, 3'd2, 2'd1, 0, RD, 0);
    tick();
    chk("lbu1", Writedata, 32'h0000_00FF);
    ins(1, 1, 3, 1, 0, 3'd3, 2'd2, 0, RD, 0);
    tick();
    chk("lh2", Writedata, 32'h0000_7F01);
    ins(1, 1, 3, 1, 0, 3'd4, 2'd0, 0, RD, 0);
    tick();
    chk("lhu0", Writedata, 32'h0000_80FF);
    chk("lhu0.we", 32'(regWr), 32'd1);

    ins(1, 1, 31, 0, 1, 0, 0, 0, 0, 32'h0040_0010);
    tick();
    chk("link.wd", Writedata, 32'h0040_0018);
    chk("link.we", 32'(regWr), 32'd1);
    ins(1, 1, 0, 0, 1, 0, 0, 0, 0, 32'h0040_0010);
    tick();
    chk("r0.we",  32'(regWr), 32'd0);
    chk("r0.fwd", 32'(fwd_valid), 32'd0);

    c0 = m_cnt;
    ins(1, 1, 8, 1, 0, 3'd0, 2'd2, 0, RD, 0);
    tick();
    chk("mis.we",  32'(regWr), 32'd0);
    chk("mis.fwd", 32'(fwd_valid), 32'd0);
    chk("mis.cnt", retire_count, c0 + 32'd1);
    iv = 0;
    tick();
    chk("mis.err", 32'(misalign_err), 32'd1);
    flush = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("mis.err.fl", 32'(misalign_err), 32'd1);

    ins(1, 1, 7, 0, 0, 0, 0, 32'h0000_CAFE, 0, 0);
    tick();
    c0 = m_cnt;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      iv = 1;
      tick();
      chk("stl.wd",  Writedata, 32'h0000_CAFE);
      chk("stl.wa",  32'(writeimport), 32'd7);
      chk("stl.we",  32'(regWr), 32'd1);
      chk("stl.cnt", retire_count, c0);
    end
    flush = 1; stall = 1; iv = 1;
    tick();
    chk("fs.we",  32'(regWr), 32'd0);
    chk("fs.cnt", retire_count, c0);

    for (int n = 0; n < 400; n++) begin
      rnd_in();
      rst_n = ($urandom_range(0, 40) != 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      tick();
      full_chk("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
